bcd_countdown_timer: RTL
========================

// Module: bcd_countdown_timer
// PURPOSE
//   Two-digit BCD down-counter that drives the traffic-light phase countdown display.
//   The phase FSM loads a duration (00-99 s) and starts the timer.
//   The timer decrements once per prescaled tick and reports expiry back to the FSM.
//   Tens and Ones feed one 7-segment BCD decoder each; both are always valid BCD (0-9).
// PARAMETERS
//   TICK_DIV  50000000  clock cycles per decrement (1 s at 50 MHz); >=2; sim uses 4
//   PW        26        prescaler width; must hold TICK_DIV-1
// PORTS
//   Clock     in   1  system clock; all state on rising edge
//   Resetn    in   1  asynchronous, active-low reset
//   Load      in   1  1-cycle strobe: capture LoadTens/LoadOnes
//   Start     in   1  1-cycle strobe: begin counting from current value
//   Enable    in   1  level; 0 = pause (count and prescaler frozen)
//   LoadTens  in   4  BCD tens digit to load
//   LoadOnes  in   4  BCD ones digit to load
//   Tens      out  4  current tens digit, to BCD decoder
//   Ones      out  4  current ones digit, to BCD decoder
//   Running   out  1  1 while state == RUN
//   Zero      out  1  1 while state == EXPIRED (display 00)
//   Done      out  1  1-cycle pulse on the edge the count reaches 00
// BEHAVIOUR
// - Reset
//   - Resetn=0 forces state IDLE, Tens=Ones=0, prescaler=0, Running=Zero=Done=0.
//   - Reset acts immediately, with no clock edge needed, including mid-count.
// - All outputs are registered.
// - States
//   - IDLE: holds value.
//   - RUN: counting.
//   - EXPIRED: holds 00.
// - Priority per edge: Load > Start > tick.
// - Load
//   - Accepted in any state.
//   - Digit >9 is clamped to 9, independently per digit.
//   - Prescaler is cleared.
//   - Load=1, Start=0: next state IDLE.
//   - Load=1, Start=1: next state RUN with the loaded value.
// - Start
//   - Acted on only in IDLE.
//   - Value !=00: go to RUN, prescaler cleared.
//   - Value ==00: go to EXPIRED; Done pulses on that edge.
//   - Ignored in RUN and EXPIRED.
// - Prescaler
//   - Counts 0..TICK_DIV-1 in RUN only while Enable=1.
//   - Tick occurs when prescaler == TICK_DIV-1 and Enable=1; prescaler then wraps to 0.
//   - First decrement lands TICK_DIV enabled cycles after entering RUN.
// - Decrement on tick
//   - Ones>0: Ones-1.
//   - Ones==0: Ones=9, Tens-1.
// - Expiry
//   - Tick from 01: value becomes 00, Done=1 for exactly that cycle, state goes to EXPIRED.
//   - Never wraps to 99.
// - Enable=0 in RUN: value and prescaler hold; Running stays 1.
// - Enable has no effect outside RUN.
// - EXPIRED: holds 00, Zero=1; only Load or reset leaves it.
// - Done never asserts in IDLE, and never on two consecutive cycles.
// TESTING (TICK_DIV=4)
// 1. Count to expiry: reset, Load+Start with 25, Enable=1.
//    - 24 appears 4 cycles later.
//    - 00 appears after 100 cycles; Done high 1 cycle; Zero=1; Running=0.
//    - Value stays 00 for 20 more cycles.
// 2. Borrow: load 10, Start.
//    - After one tick Tens=0, Ones=9.
//    - After the next tick: 08.
// 3. Pause: during RUN at 07, drop Enable for 10 cycles.
//    - Value and prescaler frozen.
//    - Resumes with the same phase; 06 arrives 4 enabled cycles after the last tick.
// 4. Clamp and priority:
//    - Load Tens=4'hA, Ones=4'hF: value reads 99.
//    - Load 05 while RUN at 12: value 05, state IDLE, Running=0.
//    - Start alone at 00: Done pulse, Zero=1.
// 5. Async reset: assert Resetn=0 between clock edges at 42 in RUN.
//    - Tens=Ones=0 and Running=0 before the next edge.
//    - No Done pulse after release.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer for the traffic-light phase display.
// Loads 00-99, decrements once per prescaled tick, and flags expiry to the phase FSM.

module bcd_digit_dec (
  input  logic [3:0] d,
  input  logic       bin,
  input  logic [3:0] ld,
  output logic [3:0] q,
  output logic       bout,
  output logic [3:0] ldq
);
  assign ldq = (ld > 4'd9) ? 4'd9 : ld;

  always_comb begin
    q    = d;
    bout = 1'b0;
    if (bin) begin
      if (d == 4'd0) begin
        q    = 4'd9;
        bout = 1'b1;
      end else begin
        q = d - 4'd1;
      end
    end
  end
endmodule

module bcd_countdown_timer #(
  parameter int TICK_DIV = 50000000,
  parameter int PW       = 26
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Load,
  input  logic       Start,
  input  logic       Enable,
  input  logic [3:0] LoadTens,
  input  logic [3:0] LoadOnes,
  output logic [3:0] Tens,
  output logic [3:0] Ones,
  output logic       Running,
  output logic       Zero,
  output logic       Done
);
  localparam int ND = 2;
  localparam logic [PW-1:0] TOP = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

  state_t               state;
  logic [PW-1:0]        presc;
  logic [ND-1:0][3:0]   dig_q, dig_dec, dig_ld, ld_raw;
  logic [ND:0]          borrow;

  assign ld_raw    = {LoadTens, LoadOnes};
  assign borrow[0] = 1'b1;

  // Per-digit decrement with borrow ripple; digit 0 is the ones digit.
  genvar g;
  generate
    for (g = 0; g < ND; g++) begin : g_dig
      bcd_digit_dec u_dig (
        .d    (dig_q[g]),
        .bin  (borrow[g]),
        .ld   (ld_raw[g]),
        .q    (dig_dec[g]),
        .bout (borrow[g+1]),
        .ldq  (dig_ld[g])
      );
    end
  endgenerate

  assign Tens = dig_q[1];
  assign Ones = dig_q[0];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= IDLE;
      dig_q   <= '0;
      presc   <= '0;
      Running <= 1'b0;
      Zero    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (Load) begin
        dig_q   <= dig_ld;
        presc   <= '0;
        Zero    <= 1'b0;
        state   <= Start ? RUN : IDLE;
        Running <= Start;
      end else if (Start && state == IDLE) begin
        presc <= '0;
        if (dig_q != '0) begin
          state   <= RUN;
          Running <= 1'b1;
        end else begin
          state <= EXPIRED;
          Zero  <= 1'b1;
          Done  <= 1'b1;
        end
      end else if (state == RUN && Enable) begin
        if (presc == TOP) begin
          presc <= '0;
          // A borrow out of the tens digit means we were already at 00: expire
          // rather than wrap to 99.
          if (dig_dec == '0 || borrow[ND]) begin
            dig_q   <= '0;
            state   <= EXPIRED;
            Running <= 1'b0;
            Zero    <= 1'b1;
            Done    <= 1'b1;
          end else begin
            dig_q <= dig_dec;
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end
endmodule
